fpu_result_collector: RTL and testbench

//  Downstream merge stage behind the FPU execution units (selector, adder, multiplier, divider, ...).

---
 rtl/fpu_result_collector.sv | 102 ++++++++++
 tb/tb_fpu_result_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_collector.sv
// FPU result merge stage: fixed-priority arbitration of unit result streams into
// an in-order result FIFO, plus the sticky accrued-exception register.

module fpu_result_collector_arb_cell (
  input  logic valid,
  input  logic higher_valid,
  input  logic space,
  output logic gnt,
  output logic ready,
  output logic chain_valid
);
  assign gnt         = valid & ~higher_valid;
  assign ready       = space & gnt;
  assign chain_valid = valid | higher_valid;
endmodule

module fpu_result_collector #(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_UNITS-1:0]   unit_valid,
  output logic [N_UNITS-1:0]   unit_ready,
  input  logic [32*N_UNITS-1:0] unit_float,
  input  logic [5*N_UNITS-1:0] unit_flags,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [31:0]          float_out,
  output logic [4:0]           flags_out,
  input  logic                 fflags_clr,
  output logic [4:0]           fflags
);
  localparam int RW = 37;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N_UNITS:0]            higher;
  logic [N_UNITS-1:0]          gnt;
  logic [N_UNITS-1:0][RW-1:0]  masked;
  logic [RW-1:0]               wr_data;
  logic [RW-1:0]               mem [DEPTH];
  logic [RW-1:0]               head;
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic [CW-1:0]               count;
  logic                        pop, push, space;

  assign valid_out = (count != '0);
  assign pop       = valid_out & ready_in;
  assign space     = (count < DEPTH_C) | pop;
  // higher[N_UNITS] is "any unit valid", so a push is simply any valid with room.
  assign push      = higher[N_UNITS] & space;
  assign higher[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < N_UNITS; i++) begin : g_unit
      fpu_result_collector_arb_cell u_cell (
        .valid        (unit_valid[i]),
        .higher_valid (higher[i]),
        .space        (space),
        .gnt          (gnt[i]),
        .ready        (unit_ready[i]),
        .chain_valid  (higher[i+1])
      );
      // AND-masking keeps non-granted unit data out of the write path entirely.
      assign masked[i] = {unit_float[32*i +: 32], unit_flags[5*i +: 5]} & {RW{gnt[i]}};
    end
  endgenerate

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < N_UNITS; k++) wr_data = wr_data | masked[k];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head      = mem[rd_ptr];
  assign float_out = valid_out ? head[RW-1:5] : 32'h0;
  assign flags_out = valid_out ? head[4:0]    : 5'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fflags <= 5'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      fflags <= (fflags_clr ? 5'h0 : fflags) | (pop ? flags_out : 5'h0);
    end
  end
endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: directed scenarios plus a randomized run against
// a queue-based scoreboard of accepted results and accrued flags.

module tb_fpu_result_collector;
  localparam int N = 4;
  localparam int D = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     unit_valid = '0;
  logic [N-1:0]     unit_ready;
  logic [32*N-1:0]  unit_float = '0;
  logic [5*N-1:0]   unit_flags = '0;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic [31:0]      float_out;
  logic [4:0]       flags_out;
  logic             fflags_clr = 1'b0;
  logic [4:0]       fflags;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] fq_val[$];
  logic [4:0]  fq_flg[$];
  logic [4:0]  m_fflags = 5'h0;
  int          m_acc = -1;

  fpu_result_collector #(.N_UNITS(N), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_float(unit_float), .unit_flags(unit_flags), .valid_out(valid_out),
    .ready_in(ready_in), .float_out(float_out), .flags_out(flags_out),
    .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    bit sp;
    r  = '0;
    sp = (fq_val.size() < D) || ((fq_val.size() != 0) && ready_in);
    for (int i = 0; i < N; i++)
      if (unit_valid[i] && sp) begin r[i] = 1'b1; break; end
    return r;
  endfunction

  function automatic logic [31:0] exp_float();
    return (fq_val.size() != 0) ? fq_val[0] : 32'h0;
  endfunction

  function automatic logic [4:0] exp_flags();
    return (fq_flg.size() != 0) ? fq_flg[0] : 5'h0;
  endfunction

  // Advance the scoreboard by one clock using the inputs currently driven.
  task automatic tick();
    bit pop_e, space_e;
    int g;
    pop_e   = (fq_val.size() != 0) && ready_in;
    space_e = (fq_val.size() < D) || pop_e;
    g = -1;
    for (int i = N - 1; i >= 0; i--) if (unit_valid[i]) g = i;
    m_fflags = (fflags_clr ? 5'h0 : m_fflags) | (pop_e ? fq_flg[0] : 5'h0);
    if (pop_e) begin
      void'(fq_val.pop_front());
      void'(fq_flg.pop_front());
    end
    m_acc = -1;
    if (space_e && g >= 0) begin
      fq_val.push_back(unit_float[32*g +: 32]);
      fq_flg.push_back(unit_flags[5*g +: 5]);
      m_acc = g;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_unit(input int u, input logic [31:0] v, input logic [4:0] f);
    unit_float[32*u +: 32] = v;
    unit_flags[5*u +: 5]   = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    vectors++; if (float_out !== 32'h0) begin miscompares++; $display("FAIL reset_float: got %h expected 0", float_out); end
    vectors++; if (flags_out !== 5'h0) begin miscompares++; $display("FAIL reset_flags: got %b expected 0", flags_out); end
    vectors++; if (fflags !== 5'h0) begin miscompares++; $display("FAIL reset_fflags: got %b expected 0", fflags); end
    vectors++; if (unit_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", unit_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    ready_in = 1'b0;
    unit_valid = 4'b0010;
    set_unit(1, 32'h3f800000, 5'h0);
    #1;
    vectors++; if (unit_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready: got %b expected 0010", unit_ready); end
    tick();
    unit_valid = '0;
    #1;
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", valid_out); end
    vectors++; if (float_out !== 32'h3f800000) begin miscompares++; $display("FAIL single_float: got %h expected 3f800000", float_out); end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %b expected 0", valid_out); end
  endtask

  task automatic test_priority();
    ready_in = 1'b1;
    unit_valid = 4'b0101;
    set_unit(0, 32'h40000000, 5'h0);
    set_unit(2, 32'h40400000, 5'h0);
    #1;
    vectors++; if (unit_ready !== 4'b0001) begin miscompares++; $display("FAIL prio_first: got %b expected 0001", unit_ready); end
    tick();
    unit_valid = 4'b0100;
    #1;
    vectors++; if (unit_ready !== 4'b0100) begin miscompares++; $display("FAIL prio_second: got %b expected 0100", unit_ready); end
    vectors++; if (float_out !== 32'h40000000) begin miscompares++; $display("FAIL prio_out0: got %h expected 40000000", float_out); end
    tick();
    unit_valid = '0;
    #1;
    vectors++; if (float_out !== 32'h40400000) begin miscompares++; $display("FAIL prio_out2: got %h expected 40400000", float_out); end
    tick();
    ready_in = 1'b0;
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL prio_empty: got %b expected 0", valid_out); end
  endtask

  task automatic test_full();
    ready_in = 1'b0;
    unit_valid = 4'b0001;
    set_unit(0, 32'h11111111, 5'h0);
    tick();
    set_unit(0, 32'h22222222, 5'h0);
    tick();
    unit_valid = 4'b1000;
    set_unit(3, 32'h33333333, 5'h0);
    set_unit(0, 32'hdeadbeef, 5'h1f);
    #1;
    vectors++; if (unit_ready !== 4'b0000) begin miscompares++; $display("FAIL full_ready: got %b expected 0000", unit_ready); end
    vectors++; if (float_out !== 32'h11111111) begin miscompares++; $display("FAIL full_head: got %h expected 11111111", float_out); end
    tick();
    vectors++; if (unit_ready !== 4'b0000) begin miscompares++; $display("FAIL full_hold_ready: got %b expected 0000", unit_ready); end
    vectors++; if (float_out !== 32'h11111111) begin miscompares++; $display("FAIL full_stable: got %h expected 11111111", float_out); end
    ready_in = 1'b1;
    #1;
    vectors++; if (unit_ready !== 4'b1000) begin miscompares++; $display("FAIL full_poppush_ready: got %b expected 1000", unit_ready); end
    tick();
    unit_valid = '0;
    #1;
    vectors++; if (float_out !== 32'h22222222) begin miscompares++; $display("FAIL full_next: got %h expected 22222222", float_out); end
    tick();
    vectors++; if (valid_out !== 1'b1 || float_out !== 32'h33333333) begin miscompares++; $display("FAIL full_third: got %b/%h expected 1/33333333", valid_out, float_out); end
    tick();
    ready_in = 1'b0;
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL full_empty: got %b expected 0", valid_out); end
  endtask

  task automatic test_flags();
    ready_in = 1'b0;
    unit_valid = 4'b0001;
    set_unit(0, 32'h7fc00000, 5'b10000);
    tick();
    unit_valid = 4'b0010;
    set_unit(1, 32'h3f800001, 5'b00001);
    tick();
    unit_valid = '0;
    #1;
    vectors++; if (flags_out !== 5'b10000) begin miscompares++; $display("FAIL flags_head: got %b expected 10000", flags_out); end
    vectors++; if (float_out !== 32'h7fc00000) begin miscompares++; $display("FAIL flags_nan: got %h expected 7fc00000", float_out); end
    ready_in = 1'b1;
    tick();
    tick();
    ready_in = 1'b0;
    #1;
    vectors++; if (fflags !== 5'b10001) begin miscompares++; $display("FAIL flags_accrue: got %b expected 10001", fflags); end
    unit_valid = 4'b0100;
    set_unit(2, 32'h7f800000, 5'b00100);
    tick();
    unit_valid = '0;
    ready_in = 1'b1;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    ready_in = 1'b0;
    #1;
    vectors++; if (fflags !== 5'b00100) begin miscompares++; $display("FAIL flags_clr_pop: got %b expected 00100", fflags); end
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    vectors++; if (fflags !== 5'b00000) begin miscompares++; $display("FAIL flags_clr: got %b expected 00000", fflags); end
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    unit_valid = 4'b0001;
    set_unit(0, 32'haaaa0001, 5'h1f);
    tick();
    set_unit(0, 32'haaaa0002, 5'h0);
    tick();
    ready_in = 1'b1;
    set_unit(0, 32'haaaa0003, 5'h0);
    tick();
    unit_valid = '0;
    ready_in = 1'b0;
    #1;
    vectors++; if (fflags !== 5'h1f) begin miscompares++; $display("FAIL rmid_fflags_pre: got %b expected 11111", fflags); end
    vectors++; if (float_out !== 32'haaaa0002) begin miscompares++; $display("FAIL rmid_head_pre: got %h expected aaaa0002", float_out); end
    reset = 1'b1;
    #1;
    fq_val.delete();
    fq_flg.delete();
    m_fflags = 5'h0;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b expected 0", valid_out); end
    vectors++; if (float_out !== 32'h0) begin miscompares++; $display("FAIL rmid_float: got %h expected 0", float_out); end
    vectors++; if (fflags !== 5'h0) begin miscompares++; $display("FAIL rmid_fflags: got %b expected 0", fflags); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rmid_release_empty: got %b expected 0", valid_out); end
    unit_valid = 4'b0010;
    set_unit(1, 32'hbbbb0004, 5'b00010);
    #1;
    vectors++; if (unit_ready !== 4'b0010) begin miscompares++; $display("FAIL rmid_accept: got %b expected 0010", unit_ready); end
    tick();
    unit_valid = '0;
    #1;
    vectors++; if (float_out !== 32'hbbbb0004 || flags_out !== 5'b00010) begin miscompares++; $display("FAIL rmid_newhead: got %h/%b expected bbbb0004/00010", float_out, flags_out); end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic test_random();
    m_acc = -1;
    unit_valid = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(unit_valid[i] && m_acc != i)) begin
          unit_valid[i] = ($urandom_range(0, 2) != 0);
          set_unit(i, $urandom(), 5'($urandom_range(0, 31)));
        end
      end
      ready_in   = ($urandom_range(0, 3) != 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      #1;
      vectors++; if ($countones(unit_ready) > 1) begin miscompares++; $display("FAIL rnd_onehot c=%0d: got %b expected at most one bit", c, unit_ready); end
      vectors++; if (unit_ready !== exp_ready()) begin miscompares++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, unit_ready, exp_ready()); end
      vectors++; if (valid_out !== (fq_val.size() != 0)) begin miscompares++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, valid_out, fq_val.size() != 0); end
      vectors++; if (float_out !== exp_float() || flags_out !== exp_flags()) begin miscompares++; $display("FAIL rnd_head c=%0d: got %h/%b expected %h/%b", c, float_out, flags_out, exp_float(), exp_flags()); end
      vectors++; if (fflags !== m_fflags) begin miscompares++; $display("FAIL rnd_fflags c=%0d: got %b expected %b", c, fflags, m_fflags); end
      tick();
    end
    unit_valid = '0;
    fflags_clr = 1'b0;
    ready_in   = 1'b1;
    for (int k = 0; k < D + 2 && fq_val.size() != 0; k++) begin
      #1;
      vectors++; if (float_out !== exp_float()) begin miscompares++; $display("FAIL rnd_drain: got %h expected %h", float_out, exp_float()); end
      tick();
    end
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rnd_final_empty: got %b expected 0", valid_out); end
    vectors++; if (fflags !== m_fflags) begin miscompares++; $display("FAIL rnd_final_fflags: got %b expected %b", fflags, m_fflags); end
    ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_flags();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
